// File: rtl/ring_phase_monitor.sv
// Ring counter phase monitor: decodes, checks rotation, tracks lock/errors.
// Optional revolution counter built only when RING_REV_COUNT_EN is defined.
module ring_phase_monitor #(
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ring_in,
  input  logic       ring_vld,
  input  logic       clr_err,
  output logic [1:0] phase,
  output logic       phase_vld,
  output logic       locked,
  output logic       err,
  output logic       err_sticky,
  output logic [7:0] rev_cnt
);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] phase_q;
  logic       pvld_q;
  logic       err_q;
  logic       stk_q;

  logic       onehot;
  logic [3:0] oh_sel;
  logic [1:0] enc;
  logic       adv;
  logic       stall;
  logic       bad;

  assign onehot = $onehot(ring_in);
  assign oh_sel = onehot ? ring_in : 4'b0001;

  always_comb begin
    enc = 2'd0;
    unique case (1'b1)
      oh_sel[3]: enc = 2'd3;
      oh_sel[2]: enc = 2'd2;
      oh_sel[1]: enc = 2'd1;
      oh_sel[0]: enc = 2'd0;
    endcase
  end

  // The stored reference is the last one-hot sample, i.e. phase/phase_vld.
  assign adv   = pvld_q && onehot && (enc == phase_q - 2'd1);
  assign stall = pvld_q && onehot && (enc == phase_q);
  assign bad   = pvld_q && !adv && !stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ring_vld) begin
      unique case (state_q)
        UNLOCKED: begin
          if (onehot) begin
            state_d = ACQUIRE;
            cnt_d   = 4'd0;
          end
        end
        ACQUIRE: begin
          if (bad) begin
            state_d = onehot ? ACQUIRE : UNLOCKED;
            cnt_d   = 4'd0;
          end else if (adv) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LOCK_N) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (bad) begin
            state_d = onehot ? ACQUIRE : UNLOCKED;
            cnt_d   = 4'd0;
          end
        end
        default: begin
          state_d = UNLOCKED;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      cnt_q   <= 4'd0;
      phase_q <= 2'd0;
      pvld_q  <= 1'b0;
      err_q   <= 1'b0;
      stk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= ring_vld && bad;
      if (ring_vld && bad) stk_q <= 1'b1;
      else if (clr_err)    stk_q <= 1'b0;
      if (ring_vld) begin
        pvld_q <= onehot;
        if (onehot) phase_q <= enc;
      end
    end
  end

`ifdef RING_REV_COUNT_EN
  logic [7:0] rev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rev_q <= 8'd0;
    end else if (ring_vld && adv && state_q == LOCKED && phase_q == 2'd0) begin
      rev_q <= rev_q + 8'd1;
    end
  end

  assign rev_cnt = rev_q;
`else
  assign rev_cnt = 8'd0;
`endif

  assign phase      = phase_q;
  assign phase_vld  = pvld_q;
  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign err_sticky = stk_q;

endmodule
